store_formatter: RTL and testbench

- Write-side counterpart of the ID-stage sign extender and the load-side extender in the MEM stage.
- Takes a store (SB/SH/SW) from EX/MEM and narrows the rt value into the correct byte lanes with byte enables.
- Checks alignment, then runs a req/ack handshake with the data memory, stalling the pipeline until the write is acknowledged.

---
 rtl/musa_mem_pkg.sv | 20 ++
 rtl/store_lane_format.sv | 48 ++++
 rtl/store_formatter.sv | 109 ++++++++++
 tb/tb_store_formatter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/musa_mem_pkg.sv
// rtl/musa_mem_pkg.sv - shared memory-stage encodings for the load and store lane logic
package musa_mem_pkg;

    // Access size as carried down the pipeline from decode
    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_t;

    // Store handshake state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/store_lane_format.sv
// rtl/store_lane_format.sv - places store data into byte lanes and checks alignment
module store_lane_format #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        aligned_ok
);
    import musa_mem_pkg::*;

    logic [3:0] be_le;

    // Replicate the narrow value across all lanes; the enables pick the lane that is written
    always_comb begin
        be_le      = BE_NONE;
        wdata      = data;
        aligned_ok = 1'b0;
        case (size)
            SZ_BYTE: begin
                wdata      = {4{data[7:0]}};
                be_le      = 4'b0001 << addr_lo;
                aligned_ok = 1'b1;
            end
            SZ_HALF: begin
                wdata      = {2{data[15:0]}};
                be_le      = addr_lo[1] ? 4'b1100 : 4'b0011;
                aligned_ok = ~addr_lo[0];
            end
            SZ_WORD: begin
                wdata      = data;
                be_le      = 4'b1111;
                aligned_ok = (addr_lo == 2'b00);
            end
            default: begin
                wdata      = data;
                be_le      = BE_NONE;
                aligned_ok = 1'b0;
            end
        endcase
    end

    // Big-endian memories number lanes the other way round; only the enables mirror
    assign be = BIG_ENDIAN ? {be_le[0], be_le[1], be_le[2], be_le[3]} : be_le;

endmodule

// File: rtl/store_formatter.sv
// rtl/store_formatter.sv - store lane formatting, alignment check and memory req/ack handshake
module store_formatter #(
    parameter int ADDR_WIDTH = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [31:0]           st_data,
    input  logic [1:0]            st_size,
    output logic                  stall,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    output logic                  misaligned,
    output logic [ADDR_WIDTH-1:0] bad_addr
);
    import musa_mem_pkg::*;

    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic [3:0]            lane_be;
    logic [31:0]           lane_wdata;
    logic                  aligned_ok;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [31:0]           wdata_nxt;
    logic [3:0]            be_nxt;
    logic                  mis_nxt;
    logic [ADDR_WIDTH-1:0] bad_nxt;

    store_lane_format #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_lane (
        .addr_lo    (st_addr[1:0]),
        .size       (st_size),
        .data       (st_data),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .aligned_ok (aligned_ok)
    );

    // Ready straight from the ack lets a zero-wait memory take one store per cycle
    assign st_ready = (state == ST_IDLE) || ((state == ST_REQ) && mem_ack);
    assign stall    = st_valid && !st_ready;
    assign accept   = st_valid && st_ready;
    assign mem_req  = (state == ST_REQ);

    // State register; reset drops any pending request immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A legal accept (re)enters REQ, an ack without a new store returns to IDLE
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = aligned_ok ? ST_REQ : ST_IDLE;
        end else if ((state == ST_REQ) && mem_ack) begin
            state_nxt = ST_IDLE;
        end
    end

    // Next values for the request fields: load on legal accept, hold while waiting for ack
    always_comb begin
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        be_nxt    = mem_be;
        mis_nxt   = 1'b0;
        bad_nxt   = bad_addr;
        if (accept && aligned_ok) begin
            addr_nxt  = {st_addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_nxt = lane_wdata;
            be_nxt    = lane_be;
        end else if (accept) begin
            be_nxt    = BE_NONE;
            mis_nxt   = 1'b1;
            bad_nxt   = st_addr;
        end else if (state_nxt == ST_IDLE) begin
            be_nxt    = BE_NONE;
        end
    end

    // Request field and fault registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= BE_NONE;
            misaligned <= 1'b0;
            bad_addr   <= '0;
        end else begin
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            mem_be     <= be_nxt;
            misaligned <= mis_nxt;
            bad_addr   <= bad_nxt;
        end
    end

endmodule

// File: tb/tb_store_formatter.sv
// tb/tb_store_formatter.sv - scoreboard bench for store_formatter (little- and big-endian instances)
module tb_store_formatter;
    import musa_mem_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_size = 2'b00;
    logic        mem_ack = 1'b0;

    logic        st_ready, stall, mem_req, misaligned;
    logic [31:0] mem_addr, mem_wdata, bad_addr;
    logic [3:0]  mem_be;

    logic        st_ready_b, stall_b, mem_req_b, misaligned_b;
    logic [31:0] mem_addr_b, mem_wdata_b, bad_addr_b;
    logic [3:0]  mem_be_b;

    exp_t        sb_q[$];
    logic [31:0] bad_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    store_formatter #(.ADDR_WIDTH(32), .BIG_ENDIAN(1'b0)) dut (
        .clock(clock), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .misaligned(misaligned), .bad_addr(bad_addr)
    );

    store_formatter #(.ADDR_WIDTH(32), .BIG_ENDIAN(1'b1)) dut_be (
        .clock(clock), .reset(reset), .st_valid(st_valid), .st_ready(st_ready_b),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .stall(stall_b),
        .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_be(mem_be_b),
        .mem_ack(mem_ack), .misaligned(misaligned_b), .bad_addr(bad_addr_b)
    );

    // Write monitor: every acknowledged request is popped from the scoreboard and compared
    always @(negedge clock) begin
        if (!reset && mem_req && mem_ack) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL write_unexpected: got addr %h be %b, scoreboard empty", mem_addr, mem_be);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.wdata || mem_be !== e.be) begin
                    n_err++;
                    $display("FAIL write_fields: got %h/%h/%b want %h/%h/%b",
                             mem_addr, mem_wdata, mem_be, e.addr, e.wdata, e.be);
                end
                n_cmp++;
                if (mem_be_b !== {e.be[0], e.be[1], e.be[2], e.be[3]} || mem_wdata_b !== e.wdata) begin
                    n_err++;
                    $display("FAIL write_big_endian: got %h/%b want %h/%b", mem_wdata_b, mem_be_b,
                             e.wdata, {e.be[0], e.be[1], e.be[2], e.be[3]});
                end
            end
        end
    end

    // Fault monitor: every misaligned pulse is popped from the fault scoreboard
    always @(negedge clock) begin
        if (!reset && misaligned) begin
            n_cmp++;
            if (bad_q.size() == 0) begin
                n_err++;
                $display("FAIL fault_unexpected: got bad_addr %h, scoreboard empty", bad_addr);
            end else begin
                logic [31:0] exp_bad;
                exp_bad = bad_q.pop_front();
                if (bad_addr !== exp_bad || mem_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL fault_fields: got bad_addr %h req %b want %h req 0",
                             bad_addr, mem_req, exp_bad);
                end
            end
        end
    end

    task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] s);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        n_cmp++;
        if (mem_req !== 1'b0 || mem_be !== 4'b0000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            misaligned !== 1'b0 || bad_addr !== 32'h0 || st_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: got req %b be %b addr %h wdata %h mis %b bad %h rdy %b want 0/0000/0/0/0/0/1",
                     mem_req, mem_be, mem_addr, mem_wdata, misaligned, bad_addr, st_ready);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_sb_delayed_ack;
        int req_cycles = 0;
        @(posedge clock); #1;
        set_store(1'b1, 32'h0000_1003, 32'hDEAD_BEEF, SZ_BYTE);
        mem_ack = 1'b0;
        sb_q.push_back('{32'h0000_1000, 32'hEFEF_EFEF, 4'b1000});
        @(negedge clock);
        n_cmp++;
        if (st_ready !== 1'b1 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL sb_idle_ready: got rdy %b stall %b want 1/0", st_ready, stall);
        end
        @(posedge clock); #1;
        @(negedge clock);
        if (mem_req) req_cycles++;
        n_cmp++;
        if (stall !== 1'b1 || st_ready !== 1'b0 || mem_be !== 4'b1000 ||
            mem_addr !== 32'h0000_1000 || mem_wdata !== 32'hEFEF_EFEF) begin
            n_err++;
            $display("FAIL sb_req_wait: got stall %b rdy %b be %b addr %h wdata %h want 1/0/1000/00001000/efefefef",
                     stall, st_ready, mem_be, mem_addr, mem_wdata);
        end
        @(posedge clock); #1;
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        @(negedge clock);
        if (mem_req) req_cycles++;
        @(posedge clock); #1;
        mem_ack = 1'b0;
        @(negedge clock);
        if (mem_req) req_cycles++;
        n_cmp++;
        if (mem_be !== 4'b0000) begin
            n_err++;
            $display("FAIL sb_be_cleared: got %b want 0000", mem_be);
        end
        @(negedge clock);
        if (mem_req) req_cycles++;
        n_cmp++;
        if (req_cycles != 2) begin
            n_err++;
            $display("FAIL sb_req_cycles: got %0d want 2", req_cycles);
        end
    endtask

    task automatic test_back_to_back;
        bit req_dropped = 1'b0;
        @(posedge clock); #1;
        set_store(1'b1, 32'h0000_2002, 32'h1234_ABCD, SZ_HALF);
        sb_q.push_back('{32'h0000_2000, 32'hABCD_ABCD, 4'b1100});
        @(posedge clock); #1;
        mem_ack = 1'b1;
        set_store(1'b1, 32'h0000_2004, 32'h0BAD_F00D, SZ_WORD);
        sb_q.push_back('{32'h0000_2004, 32'h0BAD_F00D, 4'b1111});
        @(negedge clock);
        if (!mem_req) req_dropped = 1'b1;
        n_cmp++;
        if (st_ready !== 1'b1 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_ready_on_ack: got rdy %b stall %b want 1/0", st_ready, stall);
        end
        @(posedge clock); #1;
        st_valid = 1'b0;
        @(negedge clock);
        if (!mem_req) req_dropped = 1'b1;
        n_cmp++;
        if (mem_be !== 4'b1111 || req_dropped) begin
            n_err++;
            $display("FAIL b2b_word_follow: got be %b dropped %b want 1111/0", mem_be, req_dropped);
        end
        @(posedge clock); #1;
        mem_ack = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: got req %b want 0", mem_req);
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs[0] = 32'h0000_3002; sizes[0] = SZ_WORD;
        addrs[1] = 32'h0000_3001; sizes[1] = SZ_HALF;
        addrs[2] = 32'h0000_3000; sizes[2] = SZ_ILLEGAL;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            set_store(1'b1, addrs[i], 32'hFFFF_FFFF, sizes[i]);
            bad_q.push_back(addrs[i]);
            @(posedge clock); #1;
            st_valid = 1'b0;
            @(negedge clock);
            n_cmp++;
            if (misaligned !== 1'b1 || mem_req !== 1'b0 || mem_be !== 4'b0000) begin
                n_err++;
                $display("FAIL misaligned_pulse_%0d: got mis %b req %b be %b want 1/0/0000",
                         i, misaligned, mem_req, mem_be);
            end
            @(negedge clock);
            n_cmp++;
            if (misaligned !== 1'b0 || mem_req !== 1'b0) begin
                n_err++;
                $display("FAIL misaligned_one_cycle_%0d: got mis %b req %b want 0/0", i, misaligned, mem_req);
            end
        end
    endtask

    task automatic test_ack_withheld;
        @(posedge clock); #1;
        mem_ack = 1'b1;
        @(posedge clock); #1;
        mem_ack = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (mem_req !== 1'b0 || st_ready !== 1'b1 || mem_be !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_ack_ignored: got req %b rdy %b be %b want 0/1/0000", mem_req, st_ready, mem_be);
        end
        @(posedge clock); #1;
        set_store(1'b1, 32'h0000_4000, 32'hCAFE_F00D, SZ_WORD);
        sb_q.push_back('{32'h0000_4000, 32'hCAFE_F00D, 4'b1111});
        @(posedge clock); #1;
        set_store(1'b1, 32'h0000_5001, 32'h1111_2222, SZ_BYTE);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            n_cmp++;
            if (st_ready !== 1'b0 || stall !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h0000_4000 ||
                mem_wdata !== 32'hCAFE_F00D || mem_be !== 4'b1111) begin
                n_err++;
                $display("FAIL hold_cycle_%0d: got rdy %b stall %b req %b addr %h wdata %h be %b want 0/1/1/00004000/cafef00d/1111",
                         c, st_ready, stall, mem_req, mem_addr, mem_wdata, mem_be);
            end
            @(posedge clock); #1;
        end
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        @(posedge clock); #1;
        mem_ack = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL hold_release: got req %b want 0", mem_req);
        end
    endtask

    task automatic test_reset_mid_req;
        @(posedge clock); #1;
        set_store(1'b1, 32'h0000_6001, 32'h0000_00AA, SZ_BYTE);
        @(posedge clock); #1;
        st_valid = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre_req: got req %b want 1", mem_req);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || mem_be !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_async: got req %b be %b want 0/0000", mem_req, mem_be);
        end
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (st_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_ready: got %b want 1", st_ready);
        end
        @(posedge clock); #1;
        set_store(1'b1, 32'h0000_0000, 32'h0000_0055, SZ_BYTE);
        sb_q.push_back('{32'h0000_0000, 32'h5555_5555, 4'b0001});
        @(posedge clock); #1;
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (mem_be !== 4'b0001 || mem_wdata !== 32'h5555_5555) begin
            n_err++;
            $display("FAIL rst_new_sb: got be %b wdata %h want 0001/55555555", mem_be, mem_wdata);
        end
        @(posedge clock); #1;
        mem_ack = 1'b0;
    endtask

    task automatic test_big_endian;
        @(posedge clock); #1;
        set_store(1'b1, 32'h0000_0000, 32'h0000_0077, SZ_BYTE);
        sb_q.push_back('{32'h0000_0000, 32'h7777_7777, 4'b0001});
        @(posedge clock); #1;
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (mem_be_b !== 4'b1000 || mem_req_b !== 1'b1) begin
            n_err++;
            $display("FAIL big_endian_sb: got be %b req %b want 1000/1", mem_be_b, mem_req_b);
        end
        @(posedge clock); #1;
        mem_ack = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_sb_delayed_ack();
        test_back_to_back();
        test_misaligned();
        test_ack_withheld();
        test_reset_mid_req();
        test_big_endian();
        n_cmp++;
        if (sb_q.size() != 0 || bad_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d writes %0d faults left want 0/0", sb_q.size(), bad_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
